// File: rtl/pong_bus_poller.sv
// Host-side poller for the pong core: generates the game clock and output select,
// captures the four multiplexed bus values per frame and offers them on valid/ready.
// Optional build macro PONG_AUTOPADDLE_EN: right paddle command follows the ball.
module pong_bus_poller #(
    parameter int HALF_PERIOD   = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       game_reset_req,
    input  logic       left_cmd_in,
    input  logic       right_cmd_in,
    input  logic [7:0] bus_in,
    output logic       game_clk_out,
    output logic [1:0] sel_out,
    output logic       game_reset_out,
    output logic       left_cmd_out,
    output logic       right_cmd_out,
    output logic       busy,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic [7:0] ball_x,
    output logic [7:0] ball_y,
    output logic [7:0] left_y,
    output logic [7:0] right_y
);

    localparam int CNT_W = $clog2(HALF_PERIOD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic             r_pending;
    logic             r_game_clk;
    logic             r_game_reset;
    logic             r_left_cmd;
    logic             r_right_cmd;
    logic             r_busy;
    logic             r_valid;
    logic [7:0]       r_ball_x;
    logic [7:0]       r_ball_y;
    logic [7:0]       r_left_y;
    logic [7:0]       r_right_y;

    logic w_accept;
    logic w_phase_end;
    logic w_capture;
    logic w_right_cmd;

    assign w_accept    = (r_state == IDLE) && start && !r_valid;
    assign w_phase_end = (r_cnt == CNT_LAST);
    assign w_capture   = (r_state == HIGH) && (r_cnt == CNT_CAP);

`ifdef PONG_AUTOPADDLE_EN
    // Chase the ball using the previous frame's capture
    assign w_right_cmd = (r_ball_y > r_right_y);
`else
    assign w_right_cmd = right_cmd_in;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = LOW;
            LOW:  if (w_phase_end) w_state_nxt = HIGH;
            HIGH: if (w_phase_end) w_state_nxt = (r_idx == 2'd3) ? DONE : LOW;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= 2'd0;
            r_pending    <= 1'b0;
            r_game_clk   <= 1'b0;
            r_game_reset <= 1'b0;
            r_left_cmd   <= 1'b0;
            r_right_cmd  <= 1'b0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_ball_x     <= 8'd0;
            r_ball_y     <= 8'd0;
            r_left_y     <= 8'd0;
            r_right_y    <= 8'd0;
        end else begin
            r_game_clk <= (w_state_nxt == HIGH);

            if ((r_state == LOW || r_state == HIGH) && !w_phase_end)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;

            // A request in the accept cycle is consumed by that same frame
            if (w_accept)
                r_pending <= 1'b0;
            else if (game_reset_req)
                r_pending <= 1'b1;

            if (w_accept) begin
                r_idx        <= 2'd0;
                r_left_cmd   <= left_cmd_in;
                r_right_cmd  <= w_right_cmd;
                r_game_reset <= r_pending || game_reset_req;
                r_busy       <= 1'b1;
            end

            if (r_state == HIGH && w_phase_end && r_idx != 2'd3)
                r_idx <= r_idx + 2'd1;

            if (w_capture) begin
                case (r_idx)
                    2'd0: r_ball_x  <= bus_in;
                    2'd1: r_ball_y  <= bus_in;
                    2'd2: r_left_y  <= bus_in;
                    default: r_right_y <= bus_in;
                endcase
            end

            if (r_state == DONE) begin
                r_valid      <= 1'b1;
                r_busy       <= 1'b0;
                r_game_reset <= 1'b0;
            end else if (r_valid && frame_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign game_clk_out   = r_game_clk;
    assign sel_out        = r_idx;
    assign game_reset_out = r_game_reset;
    assign left_cmd_out   = r_left_cmd;
    assign right_cmd_out  = r_right_cmd;
    assign busy           = r_busy;
    assign frame_valid    = r_valid;
    assign ball_x         = r_ball_x;
    assign ball_y         = r_ball_y;
    assign left_y         = r_left_y;
    assign right_y        = r_right_y;

endmodule

// File: tb/tb_pong_bus_poller.sv
// Directed bench for pong_bus_poller: frame timing, capture, handshake, game reset,
// mid-frame reset and the right paddle command source (PONG_AUTOPADDLE_EN aware).
module tb_pong_bus_poller;

    logic       clk;
    logic       reset;
    logic       start;
    logic       game_reset_req;
    logic       left_cmd_in;
    logic       right_cmd_in;
    logic [7:0] bus_in;
    logic       game_clk_out;
    logic [1:0] sel_out;
    logic       game_reset_out;
    logic       left_cmd_out;
    logic       right_cmd_out;
    logic       busy;
    logic       frame_valid;
    logic       frame_ready;
    logic [7:0] ball_x;
    logic [7:0] ball_y;
    logic [7:0] left_y;
    logic [7:0] right_y;

    logic       use_tbl;
    logic [7:0] bus_const;
    logic [7:0] bus_tbl [4];

    int checks;
    int errors;

    // Core model: the bus shows whichever value the select currently addresses
    assign bus_in = use_tbl ? bus_tbl[sel_out] : bus_const;

    pong_bus_poller #(.HALF_PERIOD(4), .SETTLE_CYCLES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .game_reset_req (game_reset_req),
        .left_cmd_in    (left_cmd_in),
        .right_cmd_in   (right_cmd_in),
        .bus_in         (bus_in),
        .game_clk_out   (game_clk_out),
        .sel_out        (sel_out),
        .game_reset_out (game_reset_out),
        .left_cmd_out   (left_cmd_out),
        .right_cmd_out  (right_cmd_out),
        .busy           (busy),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .ball_x         (ball_x),
        .ball_y         (ball_y),
        .left_y         (left_y),
        .right_y        (right_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic handshake();
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
    endtask

    task automatic wait_frame(output int lat, output int rises, output logic [7:0] seq,
                              output int gr_rises, output int selbad);
        logic       pclk;
        logic [1:0] psel;
        lat = -1; rises = 0; seq = 8'h00; gr_rises = 0; selbad = 0;
        pclk = game_clk_out;
        psel = sel_out;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (game_clk_out && !pclk) begin
                rises++;
                seq = {seq[5:0], sel_out};
                if (game_reset_out) gr_rises++;
            end
            if (sel_out != psel && game_clk_out) selbad++;
            pclk = game_clk_out;
            psel = sel_out;
            if (frame_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    int         lat;
    int         rises;
    int         gr_rises;
    int         selbad;
    logic [7:0] seq;
    logic       pclk;

`ifdef PONG_AUTOPADDLE_EN
    localparam logic RC_F1 = 1'b0, RC_F5 = 1'b1, RC_F6 = 1'b0;
`else
    localparam logic RC_F1 = 1'b1, RC_F5 = 1'b0, RC_F6 = 1'b1;
`endif

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; start = 1'b0; game_reset_req = 1'b0; frame_ready = 1'b0;
        left_cmd_in = 1'b0; right_cmd_in = 1'b0;
        use_tbl = 1'b0; bus_const = 8'h00;
        bus_tbl[0] = 8'd0; bus_tbl[1] = 8'd0; bus_tbl[2] = 8'd0; bus_tbl[3] = 8'd0;
        tick(); tick();
        reset = 1'b0;
        tick();

        chk("rst_game_clk", game_clk_out, 0);
        chk("rst_sel", sel_out, 0);
        chk("rst_game_reset", game_reset_out, 0);
        chk("rst_cmds", {left_cmd_out, right_cmd_out}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", frame_valid, 0);
        chk("rst_regs", {ball_x, ball_y, left_y, right_y}, 0);

        // Frame 1: constant A5 on the bus
        bus_const = 8'hA5; left_cmd_in = 1'b1; right_cmd_in = 1'b1;
        accept();
        chk("f1_busy", busy, 1);
        chk("f1_left_cmd", left_cmd_out, 1);
        chk("f1_right_cmd", right_cmd_out, RC_F1);
        wait_frame(lat, rises, seq, gr_rises, selbad);
        chk("f1_latency", lat, 33);
        chk("f1_rises", rises, 4);
        chk("f1_sel_order", seq, 8'h1B);
        chk("f1_sel_at_low", selbad, 0);
        chk("f1_busy_done", busy, 0);
        chk("f1_regs", {ball_x, ball_y, left_y, right_y}, 32'hA5A5A5A5);
        handshake();
        chk("f1_valid_clear", frame_valid, 0);

        // Frame 2: distinct value per select
        use_tbl = 1'b1;
        bus_tbl[0] = 8'd10; bus_tbl[1] = 8'd20; bus_tbl[2] = 8'd30; bus_tbl[3] = 8'd40;
        left_cmd_in = 1'b0; right_cmd_in = 1'b0;
        accept();
        chk("f2_left_cmd", left_cmd_out, 0);
        chk("f2_right_cmd", right_cmd_out, 0);
        wait_frame(lat, rises, seq, gr_rises, selbad);
        chk("f2_latency", lat, 33);
        chk("f2_ball_x", ball_x, 10);
        chk("f2_ball_y", ball_y, 20);
        chk("f2_left_y", left_y, 30);
        chk("f2_right_y", right_y, 40);

        // Back-pressure: valid and data hold, start ignored
        rises = 0; pclk = game_clk_out;
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            tick();
            if (game_clk_out && !pclk) rises++;
            pclk = game_clk_out;
        end
        start = 1'b0;
        chk("hold_valid", frame_valid, 1);
        chk("hold_busy", busy, 0);
        chk("hold_rises", rises, 0);
        chk("hold_regs", {ball_x, ball_y, left_y, right_y}, {8'd10, 8'd20, 8'd30, 8'd40});
        // Handshake and start in the same cycle: start must be dropped
        frame_ready = 1'b1; start = 1'b1;
        tick();
        frame_ready = 1'b0; start = 1'b0;
        chk("hs_valid_clear", frame_valid, 0);
        chk("hs_start_ignored", busy, 0);
        tick();
        chk("hs_still_idle", game_clk_out, 0);

        // Frame 4: pending game reset
        game_reset_req = 1'b1;
        tick();
        game_reset_req = 1'b0;
        tick();
        bus_tbl[0] = 8'd1; bus_tbl[1] = 8'd50; bus_tbl[2] = 8'd2; bus_tbl[3] = 8'd20;
        right_cmd_in = 1'b0;
        accept();
        chk("f4_game_reset", game_reset_out, 1);
        chk("f4_right_cmd", right_cmd_out, 0);
        wait_frame(lat, rises, seq, gr_rises, selbad);
        chk("f4_latency", lat, 33);
        chk("f4_gr_ticks", gr_rises, 4);
        chk("f4_gr_after", game_reset_out, 0);
        handshake();

        // Frame 5: no reset request, autopaddle sees 50 > 20
        bus_tbl[0] = 8'd0; bus_tbl[1] = 8'd5; bus_tbl[2] = 8'd0; bus_tbl[3] = 8'd20;
        right_cmd_in = 1'b0;
        accept();
        chk("f5_game_reset", game_reset_out, 0);
        chk("f5_right_cmd", right_cmd_out, RC_F5);
        wait_frame(lat, rises, seq, gr_rises, selbad);
        chk("f5_gr_ticks", gr_rises, 0);
        chk("f5_ball_y", ball_y, 5);
        handshake();

        // Frame 6: autopaddle sees 5 > 20 false
        right_cmd_in = 1'b1;
        accept();
        chk("f6_right_cmd", right_cmd_out, RC_F6);
        wait_frame(lat, rises, seq, gr_rises, selbad);
        chk("f6_latency", lat, 33);
        handshake();

        // Mid-frame reset at cycle 12, with a reset request pending
        accept();
        for (int i = 2; i <= 12; i++) begin
            game_reset_req = (i == 5);
            tick();
        end
        game_reset_req = 1'b0;
        reset = 1'b1;
        tick();
        chk("mr_game_clk", game_clk_out, 0);
        chk("mr_sel", sel_out, 0);
        chk("mr_busy", busy, 0);
        chk("mr_valid", frame_valid, 0);
        chk("mr_outs", {game_reset_out, left_cmd_out, right_cmd_out}, 0);
        chk("mr_regs", {ball_x, ball_y, left_y, right_y}, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("mr_no_valid", frame_valid, 0);
        chk("mr_idle_clk", game_clk_out, 0);
        accept();
        chk("mr_pending_cleared", game_reset_out, 0);
        wait_frame(lat, rises, seq, gr_rises, selbad);
        chk("mr_latency", lat, 33);
        handshake();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
